// File: rtl/vga_frame_reader.sv
// Scans an 8-bit grayscale framebuffer in raster order and drives centred 640x480@60 VGA.
// Define VGA_BORDER_EN to draw a white 1-pixel frame just outside the displayed image.
module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        img_w,
    input  logic [9:0]        img_h,
    input  logic              frame_valid,
    output logic [ADDR_W-1:0] ram_rdaddr,
    output logic              ram_rden,
    input  logic [7:0]        ram_q,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              pix_tick,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [TICK_W-1:0] tick_cnt;
    logic              need_latch;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              frame_end;
    logic              latch;

    // need_latch holds the raster for one clk after reset so the first frame
    // already sees the sampled image geometry at pixel (0,0).
    assign pix_tick    = ~need_latch & (tick_cnt == TICK_LAST);
    assign frame_end   = pix_tick & (hcount == H_LAST) & (vcount == V_LAST);
    assign latch       = need_latch | frame_end;
    assign frame_start = pix_tick & (hcount == 10'd0) & (vcount == 10'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt   <= '0;
            need_latch <= 1'b1;
            hcount     <= '0;
            vcount     <= '0;
        end else begin
            need_latch <= 1'b0;
            if (pix_tick) begin
                tick_cnt <= '0;
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end else if (!need_latch) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    logic [9:0] w_c, h_c, x0_c, y0_c;

    always_comb begin
        w_c  = (img_w > H_ACT_L) ? H_ACT_L : img_w;
        h_c  = (img_h > V_ACT_L) ? V_ACT_L : img_h;
        x0_c = (H_ACT_L - w_c) >> 1;
        y0_c = (V_ACT_L - h_c) >> 1;
    end

    logic       region_en;
    logic [9:0] w_l, x0, x1, y0, y1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            region_en <= 1'b0;
            w_l       <= '0;
            x0        <= '0;
            x1        <= '0;
            y0        <= '0;
            y1        <= '0;
        end else if (latch) begin
            region_en <= frame_valid & (w_c != 10'd0) & (h_c != 10'd0);
            w_l       <= w_c;
            x0        <= x0_c;
            x1        <= x0_c + w_c;
            y0        <= y0_c;
            y1        <= y0_c + h_c;
        end
    end

    logic visible, in_img, hs_raw, vs_raw, border;

    assign visible = (hcount < H_ACT_L) & (vcount < V_ACT_L);
    assign in_img  = region_en & (hcount >= x0) & (hcount < x1)
                   & (vcount >= y0) & (vcount < y1);
    assign hs_raw  = ~((hcount >= HS_BEG) & (hcount < HS_END));
    assign vs_raw  = ~((vcount >= VS_BEG) & (vcount < VS_END));

`ifdef VGA_BORDER_EN
    // One-pixel ring around the image; the visible term clips it at screen edges.
    logic [10:0] h_p1, v_p1;
    assign h_p1   = {1'b0, hcount} + 11'd1;
    assign v_p1   = {1'b0, vcount} + 11'd1;
    assign border = region_en & visible & ~in_img
                  & (h_p1 >= {1'b0, x0}) & (hcount <= x1)
                  & (v_p1 >= {1'b0, y0}) & (vcount <= y1);
`else
    assign border = 1'b0;
`endif

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] last_addr;
    logic [9:0]        col;

    assign ram_rden   = in_img;
    assign ram_rdaddr = in_img ? (row_base + ADDR_W'(col)) : last_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_base  <= '0;
            last_addr <= '0;
            col       <= '0;
        end else if (latch) begin
            row_base <= '0;
            col      <= '0;
        end else if (pix_tick && in_img) begin
            last_addr <= ram_rdaddr;
            if (col == w_l - 10'd1) begin
                col      <= '0;
                row_base <= row_base + ADDR_W'(w_l);
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // Stage 1 captures RAM data plus the pixel's flags; stage 2 forms the VGA outputs.
    logic       s1_in, s1_vis, s1_hs, s1_vs, s1_bord;
    logic [7:0] q1;
    logic [7:0] pix_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_in       <= 1'b0;
            s1_vis      <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_bord     <= 1'b0;
            q1          <= '0;
            pix_o       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
        end else if (pix_tick) begin
            s1_in       <= in_img;
            s1_vis      <= visible;
            s1_hs       <= hs_raw;
            s1_vs       <= vs_raw;
            s1_bord     <= border;
            q1          <= ram_q;
            pix_o       <= s1_in ? q1 : (s1_bord ? 8'hFF : 8'h00);
            vga_blank_n <= s1_vis;
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
        end
    end

    assign vga_r = pix_o;
    assign vga_g = pix_o;
    assign vga_b = pix_o;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a reduced-timing instance checked pixel by pixel against
// a geometry model, plus a default-timing instance checked over its first two lines.
module tb_vga_frame_reader;
  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 3;
  localparam int CD = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int AW = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- small-timing DUT ----------------
  logic [9:0]    drv_w, drv_h;
  logic          drv_fv;
  logic [AW-1:0] ram_rdaddr;
  logic          ram_rden;
  logic [7:0]    ram_q = 8'h00;
  logic          vga_hs, vga_vs, vga_blank_n;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          pix_tick, frame_start;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(CD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .img_w(drv_w), .img_h(drv_h), .frame_valid(drv_fv),
    .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden), .ram_q(ram_q),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_tick(pix_tick), .frame_start(frame_start)
  );

  always @(posedge clk) if (ram_rden) ram_q <= ram_rdaddr[7:0];

  // ---------------- default-timing DUT ----------------
  logic [9:0]    big_w = 10'd640, big_h = 10'd480;
  logic          big_fv = 1'b1;
  logic [AW-1:0] b_addr;
  logic          b_rden;
  logic [7:0]    b_q = 8'h00;
  logic          b_hs, b_vs, b_blank;
  logic [7:0]    b_r, b_g, b_b;
  logic          b_pix_tick, b_frame_start;

  vga_frame_reader big (
    .clk(clk), .reset(reset), .img_w(big_w), .img_h(big_h), .frame_valid(big_fv),
    .ram_rdaddr(b_addr), .ram_rden(b_rden), .ram_q(b_q),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_blank),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .pix_tick(b_pix_tick), .frame_start(b_frame_start)
  );

  always @(posedge clk) if (b_rden) b_q <= b_addr[7:0];

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " sync_blank"}, {29'd0, vga_hs, vga_vs, vga_blank_n}, 32'b110);
    chk({tag, " rgb"}, {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk({tag, " ram"}, {12'd0, ram_rden, ram_rdaddr}, 32'd0);
    chk({tag, " strobes"}, {30'd0, pix_tick, frame_start}, 32'd0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic mon_en = 1'b0;
  bit   mon_run = 1'b0;
  int   mh, mv, clk_k;
  int   m_w, m_h, m_x0, m_y0;
  bit   m_en;
  int   f_cnt, f_first_h, f_first_v, f_first_addr, f_last_addr;
  logic [26:0] exp_q[$];

  function automatic logic [26:0] model_pix(input int h, input int v);
    bit vis, hs, vs, inr, bord;
    int addr;
    logic [7:0] p;
    vis  = (h < HA) && (v < VA);
    hs   = !(h >= HA + HFP && h < HA + HFP + HSY);
    vs   = !(v >= VA + VFP && v < VA + VFP + VSY);
    inr  = m_en && h >= m_x0 && h < m_x0 + m_w && v >= m_y0 && v < m_y0 + m_h;
    addr = (v - m_y0) * m_w + (h - m_x0);
    bord = 1'b0;
`ifdef VGA_BORDER_EN
    bord = m_en && vis && !inr && h >= m_x0 - 1 && h <= m_x0 + m_w
           && v >= m_y0 - 1 && v <= m_y0 + m_h;
`endif
    p = inr ? addr[7:0] : (bord ? 8'hFF : 8'h00);
    return {vis, hs, vs, p, p, p};
  endfunction

  task automatic mon_tick();
    logic [26:0] e;
    bit inr;
    if (mh == 0 && mv == 0) begin
      m_w  = (drv_w > HA) ? HA : int'(drv_w);
      m_h  = (drv_h > VA) ? VA : int'(drv_h);
      m_en = drv_fv && m_w != 0 && m_h != 0;
      m_x0 = (HA - m_w) / 2;
      m_y0 = (VA - m_h) / 2;
      f_cnt = 0; f_first_h = -1; f_first_v = -1; f_first_addr = -1; f_last_addr = -1;
    end
    chk("frame_start", {31'd0, frame_start}, {31'd0, (mh == 0 && mv == 0)});
    inr = m_en && mh >= m_x0 && mh < m_x0 + m_w && mv >= m_y0 && mv < m_y0 + m_h;
    chk("ram_rden", {31'd0, ram_rden}, {31'd0, inr});
    if (inr) chk("ram_rdaddr", 32'(ram_rdaddr), 32'((mv - m_y0) * m_w + (mh - m_x0)));
    if (ram_rden === 1'b1) begin
      if (f_cnt == 0) begin
        f_first_h = mh; f_first_v = mv; f_first_addr = int'(ram_rdaddr);
      end
      f_cnt++;
      f_last_addr = int'(ram_rdaddr);
    end
    exp_q.push_back(model_pix(mh, mv));
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("pixel_out", {5'd0, vga_blank_n, vga_hs, vga_vs, vga_r, vga_g, vga_b}, {5'd0, e});
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_run = 1'b0;
      exp_q.delete();
    end else if (!mon_run) begin
      if (frame_start === 1'b1) begin
        mon_run = 1'b1; mh = 0; mv = 0; clk_k = 0;
        mon_tick();
      end
    end else begin
      clk_k++;
      chk("pix_tick", {31'd0, pix_tick}, {31'd0, (clk_k % CD) == 0});
      if (clk_k % CD == 0) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
        mon_tick();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input int h, input int v, input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(mon_run && mh == h && mv == v) && n < 8000);
    checks++;
    if (!(mon_run && mh == h && mv == v)) begin
      errors++;
      $display("FAIL wait_%s: raster (%0d,%0d) not reached, at (%0d,%0d) run=%0d", what, h, v, mh, mv, mon_run);
    end
  endtask

  task automatic check_frame(input string tag, input int cnt, input int x0, input int y0, input int last);
    chk({tag, " rden_count"}, f_cnt, cnt);
    if (cnt > 0) begin
      chk({tag, " first_h"}, f_first_h, x0);
      chk({tag, " first_v"}, f_first_v, y0);
      chk({tag, " first_addr"}, f_first_addr, 0);
      chk({tag, " last_addr"}, f_last_addr, last);
    end
  endtask

  typedef struct {
    int w; int h; int fv;
    int cnt; int x0; int y0; int last;
  } vec_t;
  vec_t tab[8];

  // ---------------- main sequence ----------------
  initial begin
    tab[0] = '{32, 24, 1, 768, 0, 0, 767};
    tab[1] = '{8, 6, 1, 48, 12, 9, 47};
    tab[2] = '{40, 24, 1, 768, 0, 0, 767};
    tab[3] = '{0, 10, 1, 0, 0, 0, 0};
    tab[4] = '{16, 12, 0, 0, 0, 0, 0};
    tab[5] = '{7, 5, 1, 35, 12, 9, 34};
    tab[6] = '{16, 30, 1, 384, 8, 0, 383};
    tab[7] = '{1, 1, 1, 1, 15, 11, 0};

    drv_w = 10'd32; drv_h = 10'd24; drv_fv = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("startup");
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    wait_pos(0, VT - 1, "frame0");
    check_frame("frame0", 768, 0, 0, 767);

    for (int i = 0; i < 8; i++) begin
      drv_w  = 10'(tab[i].w);
      drv_h  = 10'(tab[i].h);
      drv_fv = (tab[i].fv != 0);
      wait_pos(1, 0, "vec_start");
      wait_pos(0, VT - 1, "vec_end");
      check_frame($sformatf("vec%0d", i), tab[i].cnt, tab[i].x0, tab[i].y0, tab[i].last);
    end

    // geometry change mid-frame applies only from the next frame
    drv_w = 10'd16; drv_h = 10'd12; drv_fv = 1'b1;
    wait_pos(1, 0, "mid_start");
    wait_pos(0, 10, "mid_change");
    drv_w = 10'd32; drv_fv = 1'b0;
    wait_pos(0, VT - 1, "mid_end");
    check_frame("mid_current", 192, 8, 6, 191);
    wait_pos(1, 0, "next_start");
    wait_pos(0, VT - 1, "next_end");
    check_frame("mid_next", 0, 0, 0, 0);

    // reset in the middle of a frame
    drv_w = 10'd32; drv_h = 10'd24; drv_fv = 1'b1;
    wait_pos(1, 0, "rst_frame");
    wait_pos(0, 15, "rst_point");
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    begin
      int n;
      n = 0;
      while (!mon_run && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("frame_start_after_reset", {31'd0, mon_run}, 32'd1);
    end
    wait_pos(0, VT - 1, "post_reset");
    check_frame("post_reset", 768, 0, 0, 767);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- default-timing monitor ----------------
  initial begin : big_monitor
    int k, t, fall1, rise1, fall2;
    logic prev_hs;
    bit run;
    k = 0; run = 1'b0; fall1 = -1; rise1 = -1; fall2 = -1; prev_hs = 1'b1;
    @(posedge reset);
    for (int n = 0; n < 3400; n++) begin
      @(negedge clk);
      if (!run) begin
        if (b_frame_start === 1'b1) begin
          run = 1'b1;
          k = 0;
        end else begin
          continue;
        end
      end else begin
        k++;
      end
      chk("big_pix_tick", {31'd0, b_pix_tick}, {31'd0, (k % 2) == 0});
      if (k % 2 != 0) continue;
      t = k / 2;
      if (t >= 2 && t <= 641)
        chk("big_pixel", {7'd0, b_blank, b_r, b_g, b_b}, {7'd0, 1'b1, 8'(t - 2), 8'(t - 2), 8'(t - 2)});
      if (t >= 642 && t <= 801)
        chk("big_hblank", {7'd0, b_blank, b_r, b_g, b_b}, 32'd0);
      if (t == 802)
        chk("big_row1_pixel0", {23'd0, b_blank, b_r}, {23'd0, 1'b1, 8'h80});
      if (prev_hs && !b_hs) begin
        if (fall1 < 0) fall1 = t;
        else if (fall2 < 0) fall2 = t;
      end
      if (!prev_hs && b_hs && rise1 < 0) rise1 = t;
      prev_hs = b_hs;
    end
    chk("big_hs_fall_tick", fall1, 658);
    chk("big_hs_low_ticks", rise1 - fall1, 96);
    chk("big_line_clks", (fall2 - fall1) * 2, 1600);
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Read-side counterpart of the image-processing writer.
- The writer fills the 8-bit grayscale framebuffer RAM through its write port. This block scans the RAM's read port in raster order.
- Generates 640x480@60 VGA timing and outputs the stored image centred on screen on grayscale RGB.
- The image size changes per algorithm: copy, 2x/4x zoom, decimation, block average. It is therefore taken at run time and latched once per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 2, clk cycles per pixel tick (2 = 50 MHz clk to 25 MHz pixel rate)
- ADDR_W, 19, RAM read address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- img_w  in  10  stored image width in pixels
- img_h  in  10  stored image height in lines
- frame_valid  in  1  writer's done flag; image is shown only when high
- ram_rdaddr  out  ADDR_W  framebuffer read address
- ram_rden  out  1  read enable
- ram_q  in  8  RAM read data; latency 1 clk, must be <= CLK_DIV
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  high in the visible area
- vga_r, vga_g, vga_b  out  8 each  pixel value; grayscale, all three equal
- pix_tick  out  1  one-clk strobe per pixel, for the DAC clock
- frame_start  out  1  one pixel-tick pulse at hcount=0, vcount=0

Behaviour:
- Reset: tick counter, hcount, vcount, row_base and col all 0. Outputs:
  - vga_hs=1, vga_vs=1, vga_blank_n=0
  - rgb=0, ram_rden=0, ram_rdaddr=0
  - pix_tick=0, frame_start=0
- Reset asserted mid-frame aborts immediately. Scanning resumes at hcount=0, vcount=0 after release.
- Tick: a counter 0..CLK_DIV-1. pix_tick is high on the clk where the counter = CLK_DIV-1. All raster state advances only on pix_tick.
- Counters:
  - hcount runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - vcount increments when hcount wraps and runs 0..V_TOTAL-1 (525). Both wrap to 0.
- Frame latch: at each frame start, img_w and img_h are captured. Values > 640 / > 480 are clamped to 640 / 480. frame_valid is captured as show.
  - All three are constant for the whole frame. Changes mid-frame take effect at the next frame.
- Origin: x0 = (640 - w_l) >> 1 and y0 = (480 - h_l) >> 1. Both are computed at the latch.
- In-image region: x0 <= hcount < x0+w_l and y0 <= vcount < y0+h_l. The region exists only when show=1 and w_l, h_l are both nonzero. If w_l=0 or h_l=0, the screen is all black.
- Addressing: ram_rdaddr = row_base + col. No multiplier is used.
  - col counts 0..w_l-1 inside the region.
  - row_base resets to 0 at frame start.
  - row_base += w_l at the end of each in-image line.
  - The last address is w_l*h_l-1, at most 307199, which fits in 19 bits.
- ram_rden is high for in-image pixels only. Outside the region ram_rdaddr holds its last value.
- Pipeline, 2 pixel ticks:
  - T0: address issued.
  - T1: ram_q registered.
  - T2: rgb, blank_n, hs and vs driven.
  - The sync and blank signals are delayed 2 ticks so they stay aligned with the pixel data.
- Pixel output:
  - In-image pixel: rgb = ram_q.
  - Visible but outside the image: rgb = 0.
  - Blanking: rgb = 0 and vga_blank_n = 0.
- Sync:
  - vga_hs = 0 for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vga_vs is driven the same way on vcount.
- frame_start pulses for one pix_tick at hcount=0, vcount=0, undelayed. It pulses after every reset release.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: when show=1, a 1-pixel frame of value 8'hFF is drawn just outside the image rectangle.
  - The frame is clipped to the visible area, so it is absent on any side where the image touches the screen edge.
  - The border does not affect RAM addressing or ram_rden.
- Undefined: no border logic; pixels outside the image are 0.

Test Plan:
- Reset and timing: release reset, run 2 frames at CLK_DIV=2.
  - One line is 1600 clk.
  - hs is low for 96 ticks starting at hcount 656.
  - vs is low on lines 490..491.
  - frame_start period is 420000 ticks.
- Full frame: img 640x480, frame_valid=1, RAM holds addr[7:0].
  - The first visible pixel is 0x00 at 2 ticks after (h=0, v=0).
  - The last rdaddr is 307199.
  - rgb equals the pixel at (x,y) = (y*640+x)[7:0].
- Decimated image: img 160x120.
  - x0=240, y0=180.
  - The first rden is at h=240, v=180 with addr 0.
  - Line 181 starts at addr 160.
  - The last addr is 19199.
  - Pixels outside the image are 0.
- Mid-frame changes: at v=100 change img_w 320→640 and drop frame_valid.
  - The current frame is unchanged.
  - The next frame is all black with rden=0.
- Corner cases:
  - img_w=700 is clamped, giving x0=0.
  - img_w=0 gives rden never asserted.
  - Reset asserted at v=300: all outputs go to their reset values within 1 clk.
- VGA_BORDER_EN with img 320x240: rgb=0xFF at h=159, v=119..360, and at v=119, h=159..480.
